// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to count down from width to zero inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/response bundle between a requester and the multiplier.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );
endinterface

// File: rtl/shift_add_multiplier_add_stage.sv
// Combinational ripple-carry adder built from single-bit full-adder cells.
module mult_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module mult_add_stage #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = carry_in;
    assign carry_out  = w_carry[WIDTH];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            mult_fa u_fa (
                .i_a (a[gi]),
                .i_b (b[gi]),
                .i_c (w_carry[gi]),
                .o_s (sum[gi]),
                .o_c (w_carry[gi+1])
            );
        end
    endgenerate
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier with start/ready/done handshake.
// Optional macro MULT_ZERO_SKIP_EN: zero operands bypass RUN and finish immediately.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_add_multiplier_if.slave bus
);
    localparam int CNT_W = cnt_w(WIDTH);

    state_t               r_state;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_q;
    logic                 r_c;
    logic [CNT_W-1:0]     r_count;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [WIDTH-1:0]     w_a_sel;
    logic                 w_c_sel;

    mult_add_stage #(.WIDTH(WIDTH)) u_add (
        .a         (r_a),
        .b         (r_m),
        .carry_in  (1'b0),
        .sum       (w_sum),
        .carry_out (w_cout)
    );

    // Add the multiplicand only when the current multiplier bit is set.
    assign {w_c_sel, w_a_sel} = r_q[0] ? {w_cout, w_sum} : {r_c, r_a};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_c       <= 1'b0;
            r_count   <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_m     <= bus.a;
                        r_q     <= bus.b;
                        r_a     <= '0;
                        r_c     <= 1'b0;
                        r_count <= CNT_W'(WIDTH);
                        r_ready <= 1'b0;
`ifdef MULT_ZERO_SKIP_EN
                        if (bus.a == '0 || bus.b == '0) begin
                            r_product <= '0;
                            r_state   <= S_DONE;
                        end else
`endif
                        begin
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (r_count == '0) begin
                        r_product <= {r_a, r_q};
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        {r_c, r_a, r_q} <= {w_c_sel, w_a_sel, r_q} >> 1;
                        r_count         <= r_count - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // The skip path enters here with done low and raises it one cycle later.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: cycle-level timing/product model plus directed literal cases.
module tb_shift_add_multiplier;
    localparam int W = 4;
`ifdef MULT_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    shift_add_multiplier_if #(.WIDTH(W)) bus ();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_skip(input logic [W-1:0] av, input logic [W-1:0] bv);
        return SKIP && (av == '0 || bv == '0);
    endfunction

    // Edges from acceptance to the done cycle.
    function automatic int op_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
        return is_skip(av, bv) ? 1 : W + 1;
    endfunction

    // Model: timestamps (in posedge counts) of the current operation's milestones.
    int               cyc       = 0;
    int               m_ready_at = 0;
    int               m_done_at = -1;
    int               m_busy_lo = 1;
    int               m_busy_hi = 0;
    logic [2*W-1:0]   m_pending = '0;
    logic [2*W-1:0]   m_prod    = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ready_at <= 0;
            m_done_at  <= -1;
            m_busy_lo  <= 1;
            m_busy_hi  <= 0;
            m_prod     <= '0;
        end else begin
            if (bus.start && cyc >= m_ready_at) begin
                m_done_at  <= cyc + 1 + op_lat(bus.a, bus.b);
                m_ready_at <= cyc + 2 + op_lat(bus.a, bus.b);
                m_busy_lo  <= is_skip(bus.a, bus.b) ? 1 : cyc + 1;
                m_busy_hi  <= is_skip(bus.a, bus.b) ? 0 : cyc + 1 + W;
                m_pending  <= {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};
            end
            if (cyc + 1 == m_done_at)
                m_prod <= m_pending;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        logic e_ready, e_busy, e_done;
        e_ready = !rst_n || (cyc >= m_ready_at);
        e_busy  = rst_n && (cyc >= m_busy_lo) && (cyc <= m_busy_hi);
        e_done  = rst_n && (cyc == m_done_at);
        chk("ready", 16'(bus.ready), 16'(e_ready));
        chk("busy",  16'(bus.busy),  16'(e_busy));
        chk("done",  16'(bus.done),  16'(e_done));
        if (!rst_n)
            chk("product_rst", 16'(bus.product), 16'h0);
        else if (e_done || e_ready)
            chk("product", 16'(bus.product), 16'(m_prod));
    end

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready) return;
        end
        chk("ready_timeout", 16'(bus.ready), 16'h1);
    endtask

    // mode 0: single start pulse; 1: retry F*F on RUN cycle 2; 2: random junk while busy.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int mode,
                          output int lat, output logic [2*W-1:0] p);
        wait_ready();
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        lat = 0;
        p   = '0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (bus.done) begin
                p = bus.product;
                bus.start = 1'b0;
                break;
            end
            if (mode == 2) begin
                bus.start = 1'($urandom);
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
            end else if (mode == 1 && lat == 2) begin
                bus.start = 1'b1;
                bus.a     = 4'hF;
                bus.b     = 4'hF;
            end else begin
                bus.start = 1'b0;
            end
        end
        if (!bus.done) chk("done_timeout", 16'(bus.done), 16'h1);
        bus.start = 1'b0;
        $display("op a=%h b=%h product=%h latency=%0d", av, bv, p, lat);
    endtask

    initial begin
        int lat, lat2;
        logic [2*W-1:0] p;
        logic [W-1:0] av, bv;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 16'(bus.ready), 16'h1);
        chk("rst_product", 16'(bus.product), 16'h0);
        #2 rst_n = 1'b1;

        run_op(4'hF, 4'hF, 0, lat, p);
        chk("t1_prod", 16'(p), 16'h00E1);
        chk("t1_lat", 16'(lat), 16'(W + 2));

        run_op(4'h3, 4'h5, 0, lat, p);
        chk("t2a_prod", 16'(p), 16'h000F);
        chk("t2a_lat", 16'(lat), 16'(W + 2));
        run_op(4'h5, 4'h3, 0, lat, p);
        chk("t2b_prod", 16'(p), 16'h000F);
        chk("t2b_lat", 16'(lat), 16'(W + 2));

        run_op(4'h0, 4'h9, 0, lat, p);
        chk("t3_prod", 16'(p), 16'h0000);
        chk("t3_lat", 16'(lat), SKIP ? 16'd2 : 16'(W + 2));

        run_op(4'h7, 4'h6, 1, lat, p);
        chk("t4_prod", 16'(p), 16'h002A);
        chk("t4_lat", 16'(lat), 16'(W + 2));

        // Start held high across two operations.
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 4'h2;
        bus.b     = 4'h8;
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
        end
        chk("t6a_prod", 16'(bus.product), 16'h0010);
        chk("t6a_lat", 16'(lat), 16'(W + 2));
        bus.a = 4'hA;
        bus.b = 4'hB;
        lat2 = 0;
        while (lat2 < 30) begin
            @(negedge clk);
            lat2++;
            if (lat2 == 2) bus.start = 1'b0;
            if (bus.done) break;
        end
        chk("t6b_prod", 16'(bus.product), 16'h006E);
        chk("t6b_lat", 16'(lat2), 16'(W + 3));
        $display("op a=a b=b held-start product=%h latency=%0d", bus.product, lat2);
        bus.start = 1'b0;

        // Reset on RUN cycle 2 aborts with no done pulse.
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 4'h9;
        bus.b     = 4'hD;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_done", 16'(bus.done), 16'h0);
        chk("t5_product", 16'(bus.product), 16'h0);
        chk("t5_ready", 16'(bus.ready), 16'h1);
        chk("t5_busy", 16'(bus.busy), 16'h0);
        $display("reset mid-operation: ready=%b busy=%b done=%b product=%h",
                 bus.ready, bus.busy, bus.done, bus.product);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            av = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            bv = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(av, bv, 2, lat, p);
            chk("rand_prod", 16'(p), 16'({{W{1'b0}}, av} * {{W{1'b0}}, bv}));
            chk("rand_lat", 16'(lat), 16'(op_lat(av, bv) + 1));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
